vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_fb_arbiter.sv | 155 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter.
// The geometry constants are the defaults for the top-level parameters.
// PIX_LATENCY is the number of clocks from the fetch cycle to the pixel
// output.
package vga_pkg;

  localparam int HSS         = 144;
  localparam int VSS         = 35;
  localparam int IMG_W       = 256;
  localparam int IMG_H       = 256;
  localparam int PIX_LATENCY = 2;

  // Arbiter FSM: IDLE can grant a CPU access; CPU_ACK is the single completion cycle
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CPU_ACK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for timing and control bits that must stay
// aligned with the pixel pipeline. All stages clear on reset.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the input through DEPTH registers, clearing every stage on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter between the VGA scan-out and a CPU.
// The scan-out always wins the RAM port inside the image window.
// The CPU is granted only outside the window, and never in its own ack
// cycle. The window is an IMG_W x IMG_H image placed at raw counters
// HSS/VSS. Fetched pixels and the sync signals leave the block
// PIX_LATENCY clocks after the fetch cycle.
module vga_fb_arbiter #(
  parameter int IMG_W = vga_pkg::IMG_W,
  parameter int IMG_H = vga_pkg::IMG_H,
  parameter int HSS   = vga_pkg::HSS,
  parameter int VSS   = vga_pkg::VSS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  posx,
  input  logic [8:0]  posy,
  input  logic        H_Sync_in,
  input  logic        V_Sync_in,
  input  logic        Blank_n_in,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pixel,
  output logic        H_Sync,
  output logic        V_Sync,
  output logic        Blank_n,
  output logic        frame_done
);

  import vga_pkg::arb_state_e;
  import vga_pkg::ST_IDLE;
  import vga_pkg::ST_CPU_ACK;
  import vga_pkg::PIX_LATENCY;

  localparam int XW = $clog2(IMG_W);

  arb_state_e  r_state;
  arb_state_e  w_stateNext;
  logic        w_grant;
  logic [9:0]  w_ix;
  logic [9:0]  w_iy;
  logic        w_inWin;
  logic        w_lastPix;
  logic [15:0] w_pixAddr;
  logic [2:0]  w_syncDly;
  logic [1:0]  w_winDly;
  logic [7:0]  r_pixel;
  logic        r_frameDone;

  // Image-relative coordinates. Counts left of or above the image wrap
  // to large values, so one unsigned compare per axis tests the window.
  assign w_ix = posx - 10'(HSS);
  assign w_iy = {1'b0, posy} - 10'(VSS);

  // Reset also blocks the window, so every RAM-port output reads zero
  // while reset is held.
  assign w_inWin   = Blank_n_in & (w_ix < 10'(IMG_W)) & (w_iy < 10'(IMG_H)) & ~rst;
  assign w_lastPix = w_inWin & (w_ix == 10'(IMG_W - 1)) & (w_iy == 10'(IMG_H - 1));
  assign w_pixAddr = 16'({w_iy, w_ix[XW-1:0]});

  // Arbiter state register; reset drops any in-flight CPU transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: grant only from IDLE and only when scan-out is outside the window
  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_inWin && cpu_req && !rst) begin
          w_grant     = 1'b1;
          w_stateNext = ST_CPU_ACK;
        end
      end
      ST_CPU_ACK: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // RAM port mux: scan-out first, then a granted CPU access, otherwise a parked idle port
  always_comb begin
    mem_addr  = 16'h0000;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (w_inWin) begin
      mem_addr = w_pixAddr;
    end else if (w_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // The RAM returns read data one clock after the grant, which is the ack cycle.
  assign cpu_ack   = (r_state == ST_CPU_ACK);
  assign cpu_rdata = cpu_ack ? mem_rdata : 8'h00;

  // The sync and blank signals pass through the full pixel latency.
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LATENCY)
  ) u_syncDelay (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data ({H_Sync_in, V_Sync_in, Blank_n_in}),
    .o_data (w_syncDly)
  );

  // The window and last-pixel flags are delayed to line up with mem_rdata.
  // The output register below supplies the final stage.
  vga_delay_line #(
    .WIDTH (2),
    .DEPTH (PIX_LATENCY - 1)
  ) u_winDelay (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data ({w_inWin, w_lastPix}),
    .o_data (w_winDly)
  );

  // Output stage: capture fetched pixel data only for window cycles, and raise the end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel     <= 8'h00;
      r_frameDone <= 1'b0;
    end else begin
      r_pixel     <= w_winDly[1] ? mem_rdata : 8'h00;
      r_frameDone <= w_winDly[0];
    end
  end

  assign pixel      = r_pixel;
  assign frame_done = r_frameDone;
  assign H_Sync     = w_syncDly[2];
  assign V_Sync     = w_syncDly[1];
  assign Blank_n    = w_syncDly[0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter.
// A behavioural single-port RAM sits on the memory side. A scoreboard
// queue holds the expected pixel, sync and frame_done values for each
// driven cycle, and these are compared when they emerge two cycles later.
// The CPU arbitration scenarios are checked directly around each
// stimulus cycle.
module tb_vga_fb_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        hsIn;
  logic        vsIn;
  logic        blankIn;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pixel;
  logic        H_Sync;
  logic        V_Sync;
  logic        Blank_n;
  logic        frame_done;

  logic [7:0]  ramArr [65536];
  logic [11:0] sbQ [$];

  logic        reqNext;
  logic        weNext;
  logic [15:0] addrNext;
  logic [7:0]  wdataNext;

  int checkCount = 0;
  int passCount  = 0;
  int winAcks;

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .posx       (posx),
    .posy       (posy),
    .H_Sync_in  (hsIn),
    .V_Sync_in  (vsIn),
    .Blank_n_in (blankIn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pixel      (pixel),
    .H_Sync     (H_Sync),
    .V_Sync     (V_Sync),
    .Blank_n    (Blank_n),
    .frame_done (frame_done)
  );

  // Pixel clock with the rising edge at 5 ns and a 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM with a read latency of one clock
  always @(posedge clk) begin
    if (mem_we) ramArr[mem_addr] <= mem_wdata;
    mem_rdata <= ramArr[mem_addr];
  end

  // Stops a hung run after printing a failure line
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 50000 ns");
    $fatal(1, "[TB] timeout");
  end

  // Counts one comparison and reports it if it fails
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Runs one cycle:
  //   - compares the scoreboard entry that is due this cycle;
  //   - drives the new timing and CPU inputs at the falling edge;
  //   - pushes the outputs expected two cycles later.
  task automatic applyStimulus(input int px, input int py, input logic bl);
    logic [11:0] expVal;
    logic        h;
    logic        v;
    logic        win;
    int          addr;
    @(negedge clk);
    if (sbQ.size() >= 2)
      checkOutput("pipe{pix,hs,vs,blank,fd}", {20'h0, pixel, H_Sync, V_Sync, Blank_n, frame_done},
                  {20'h0, sbQ.pop_front()});
    h = 1'($urandom_range(0, 1));
    v = 1'($urandom_range(0, 1));
    posx      = 10'(px);
    posy      = 9'(py);
    blankIn   = bl;
    hsIn      = h;
    vsIn      = v;
    cpu_req   = reqNext;
    cpu_we    = weNext;
    cpu_addr  = addrNext;
    cpu_wdata = wdataNext;
    win  = bl && (px >= 144) && (px < 400) && (py >= 35) && (py < 291);
    addr = (py - 35) * 256 + (px - 144);
    expVal = {(win ? ramArr[16'(addr)] : 8'h00), h, v, bl, (win && px == 399 && py == 290)};
    sbQ.push_back(expVal);
  endtask

  initial begin
    rst = 1'b1;
    posx = '0; posy = '0; hsIn = 0; vsIn = 0; blankIn = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    reqNext = 0; weNext = 0; addrNext = '0; wdataNext = '0;
    for (int a = 0; a < 65536; a++) ramArr[a] = 8'(a ^ (a >> 8) ^ 8'h3C);
    ramArr[0] = 8'hAB;

    // Reset state
    #12;
    checkOutput("rst_ack", cpu_ack, 0);
    checkOutput("rst_pixel", pixel, 0);
    checkOutput("rst_sync", {H_Sync, V_Sync, Blank_n}, 0);
    checkOutput("rst_fd", frame_done, 0);
    checkOutput("rst_memwe", mem_we, 0);
    checkOutput("rst_memaddr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // First image pixel fetch; 0xAB should emerge two cycles later
    applyStimulus(144, 35, 1);
    #1;
    checkOutput("first_pix_addr", mem_addr, 16'h0000);
    checkOutput("first_pix_we", mem_we, 0);
    for (int x = 145; x <= 152; x++) applyStimulus(x, 35, 1);
    applyStimulus(0, 35, 0);
    applyStimulus(1, 35, 0);

    // CPU write outside the window, then read it back
    reqNext = 1; weNext = 1; addrNext = 16'h1234; wdataNext = 8'h5A;
    applyStimulus(10, 100, 0);
    #1;
    checkOutput("wr_grant_addr", mem_addr, 16'h1234);
    checkOutput("wr_grant_we", mem_we, 1);
    checkOutput("wr_grant_wdata", mem_wdata, 8'h5A);
    checkOutput("wr_grant_noack", cpu_ack, 0);
    applyStimulus(11, 100, 0);
    #1;
    checkOutput("wr_ack", cpu_ack, 1);
    checkOutput("wr_ack_no_regrant", mem_we, 0);
    reqNext = 0;
    applyStimulus(12, 100, 0);
    #1;
    checkOutput("wr_ack_pulse", cpu_ack, 0);
    reqNext = 1; weNext = 0;
    applyStimulus(13, 100, 0);
    #1;
    checkOutput("rd_grant_addr", mem_addr, 16'h1234);
    checkOutput("rd_grant_we", mem_we, 0);
    applyStimulus(14, 100, 0);
    #1;
    checkOutput("rd_ack", cpu_ack, 1);
    checkOutput("rd_data", cpu_rdata, 8'h5A);
    reqNext = 0;
    applyStimulus(15, 100, 0);

    // Request held across a full image line; grant at posx=400
    reqNext = 1; weNext = 0; addrNext = 16'h1234;
    winAcks = 0;
    for (int x = 144; x <= 399; x++) begin
      applyStimulus(x, 40, 1);
      #1;
      if (cpu_ack || mem_we) winAcks++;
      if (x == 200) checkOutput("vga_owns_addr", mem_addr, 16'h0538);
    end
    checkOutput("line_no_grant", winAcks, 0);
    applyStimulus(400, 40, 1);
    #1;
    checkOutput("line_end_grant", mem_addr, 16'h1234);
    checkOutput("line_end_noack", cpu_ack, 0);
    applyStimulus(401, 40, 1);
    #1;
    checkOutput("line_end_ack", cpu_ack, 1);
    checkOutput("line_end_rdata", cpu_rdata, 8'h5A);
    reqNext = 0;
    applyStimulus(402, 40, 1);

    // Request withdrawn inside the window is cancelled without an ack
    reqNext = 1; weNext = 1; addrNext = 16'h2222; wdataNext = 8'h11;
    applyStimulus(150, 50, 1);
    reqNext = 0;
    applyStimulus(151, 50, 1);
    applyStimulus(0, 50, 0);
    #1;
    checkOutput("cancel_noack", cpu_ack, 0);
    checkOutput("cancel_nowe", mem_we, 0);
    applyStimulus(1, 50, 0);
    #1;
    checkOutput("cancel_noack2", cpu_ack, 0);
    checkOutput("cancel_nowrite", ramArr[16'h2222], 8'(16'h2222 ^ 16'h0022 ^ 16'h003C));

    // Left edge (posx=143) is outside the window: the write is granted.
    // The ack cycle then hands the port back to the scan-out.
    reqNext = 1; weNext = 1; addrNext = 16'h0101; wdataNext = 8'h77;
    applyStimulus(143, 36, 1);
    #1;
    checkOutput("left_edge_grant", mem_addr, 16'h0101);
    checkOutput("left_edge_we", mem_we, 1);
    applyStimulus(144, 36, 1);
    #1;
    checkOutput("left_edge_ack", cpu_ack, 1);
    checkOutput("ack_cycle_vga", mem_addr, 16'h0100);
    reqNext = 0;
    applyStimulus(145, 36, 1);
    applyStimulus(146, 36, 1);

    // Bottom edge (posy=291) is outside the window: the read is granted
    reqNext = 1; weNext = 0; addrNext = 16'h0101;
    applyStimulus(200, 291, 1);
    #1;
    checkOutput("bottom_grant", mem_addr, 16'h0101);
    applyStimulus(201, 291, 1);
    #1;
    checkOutput("bottom_ack", cpu_ack, 1);
    checkOutput("bottom_rdata", cpu_rdata, 8'h77);
    reqNext = 0;
    applyStimulus(202, 291, 1);

    // Last image pixel gives exactly one frame_done pulse, two cycles later
    applyStimulus(398, 290, 1);
    applyStimulus(399, 290, 1);
    #1;
    checkOutput("last_addr", mem_addr, 16'hFFFF);
    applyStimulus(400, 290, 1);
    #1;
    checkOutput("fd_early", frame_done, 0);
    applyStimulus(401, 290, 0);
    #1;
    checkOutput("fd_pulse", frame_done, 1);
    applyStimulus(402, 290, 0);
    #1;
    checkOutput("fd_single", frame_done, 0);

    // Reset asserted in the grant cycle of a CPU read
    reqNext = 1; weNext = 0; addrNext = 16'h0101;
    applyStimulus(10, 300, 0);
    #1;
    checkOutput("rst_grant", mem_addr, 16'h0101);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_ack", cpu_ack, 0);
    checkOutput("rstmid_memaddr", mem_addr, 0);
    checkOutput("rstmid_memwe", mem_we, 0);
    checkOutput("rstmid_outs", {pixel, H_Sync, V_Sync, Blank_n, frame_done}, 0);
    @(negedge clk);
    reqNext = 0;
    cpu_req = 1'b0;
    rst = 1'b0;
    sbQ.delete();
    applyStimulus(11, 300, 0);
    #1;
    checkOutput("post_rst_noack", cpu_ack, 0);
    applyStimulus(12, 300, 0);
    #1;
    checkOutput("post_rst_noack2", cpu_ack, 0);
    reqNext = 1;
    applyStimulus(13, 300, 0);
    #1;
    checkOutput("post_rst_grant", mem_addr, 16'h0101);
    applyStimulus(14, 300, 0);
    #1;
    checkOutput("post_rst_ack", cpu_ack, 1);
    checkOutput("post_rst_rdata", cpu_rdata, 8'h77);
    reqNext = 0;
    applyStimulus(15, 300, 0);
    applyStimulus(16, 300, 0);
    applyStimulus(17, 300, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
